// File: rtl/demux8_rr_dispatch_pkg.sv
// Shared constants, FSM state type and select decode for the 1:8 round-robin dispatcher.
package demux8_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NCH-1:0] onehot8(input logic [SELW-1:0] s);
    logic [NCH-1:0] v;
    v = {{(NCH-1){1'b0}}, 1'b1} << s;
    return v;
  endfunction

endpackage

// File: rtl/demux8_rr_dispatch_rr_pick8.sv
// Combinational round-robin picker: first set mask bit at or after ptr, modulo 8.
module rr_pick8
  import demux8_pkg::*;
(
  input  logic [SELW-1:0] ptr,
  input  logic [NCH-1:0]  mask,
  output logic [SELW-1:0] grant,
  output logic            any
);

  logic [2*NCH-1:0] dbl_s;
  logic [NCH-1:0]   rot_s;
  logic [SELW-1:0]  enc_s;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    dbl_s = {mask, mask} >> ptr;
    rot_s = dbl_s[NCH-1:0];
    enc_s = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        enc_s = 3'(i);
      end else begin
        enc_s = enc_s;
      end
    end
    grant = enc_s + ptr;
    any   = |mask;
  end

endmodule

// File: rtl/demux8_rr_dispatch.sv
// Round-robin dispatcher owning the select and one-hot enable of a 1:8 demux stage.
module demux8_rr_dispatch
  import demux8_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [NCH-1:0]  ch_en,
  input  logic [NCH-1:0]  sink_ready,
  output logic [NCH-1:0]  out_valid,
  output logic [DW-1:0]   out_data,
  output logic [SELW-1:0] sel,
  output logic            stall
);

  state_t          state_r;
  logic [SELW-1:0] ptr_r;
  logic [SELW-1:0] sel_r;
  logic [DW-1:0]   data_r;
  logic [NCH-1:0]  ov_r;

  logic            xfer_s;
  logic            accept_s;
  logic [SELW-1:0] ptr_post_s;
  logic [SELW-1:0] grant_s;
  logic            any_s;

  // The grant search starts from the pointer as it will be after this cycle's transfer,
  // so a word accepted while the previous one drains goes to the next channel in turn.
  assign xfer_s     = (state_r == HOLD) && sink_ready[sel_r];
  assign ptr_post_s = xfer_s ? (sel_r + 3'd1) : ptr_r;

  rr_pick8 u_pick (
    .ptr   (ptr_post_s),
    .mask  (ch_en),
    .grant (grant_s),
    .any   (any_s)
  );

  assign in_ready = ((state_r == IDLE) || sink_ready[sel_r]) && any_s;
  assign accept_s = in_valid && in_ready;
  assign stall    = in_valid && !any_s;

  // FSM with held word, select, one-hot valid and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      sel_r   <= 3'd0;
      data_r  <= '0;
      ov_r    <= 8'h00;
    end else begin
      ptr_r <= ptr_post_s;
      case (state_r)
        IDLE, HOLD: begin
          if (accept_s) begin
            state_r <= HOLD;
            sel_r   <= grant_s;
            data_r  <= in_data;
            ov_r    <= onehot8(grant_s);
          end else if (xfer_s) begin
            state_r <= IDLE;
            ov_r    <= 8'h00;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
          ov_r    <= 8'h00;
        end
      endcase
    end
  end

  assign sel       = sel_r;
  assign out_data  = data_r;
  assign out_valid = ov_r;

endmodule

// File: tb/tb_demux8_rr_dispatch.sv
// Directed self-checking bench for demux8_rr_dispatch.
module tb_demux8_rr_dispatch;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] ch_en;
  logic [7:0] sink_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       stall;

  int checks;
  int failures;

  demux8_rr_dispatch #(.DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ch_en      (ch_en),
    .sink_ready (sink_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sel        (sel),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    ch_en      = 8'h00;
    sink_ready = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    ch_en    = 8'hA0;
    in_valid = 1'b1;
    #1;
    checks += 5;
    if (out_valid !== 8'h00) begin failures++; $display("FAIL reset_ov got=%h exp=00", out_valid); end
    if (sel !== 3'd0)        begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    if (out_data !== 8'h00)  begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    if (stall !== 1'b0)      begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    in_valid = 1'b0;
  endtask

  task automatic test_stream_all();
    logic [7:0] exp_ov;
    apply_reset();
    ch_en      = 8'hFF;
    sink_ready = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready); end
      @(posedge clk);
      #1;
      exp_ov = 8'h01 << (k % 8);
      checks += 3;
      if (sel !== 3'(k % 8))  begin failures++; $display("FAIL stream_sel k=%0d got=%0d exp=%0d", k, sel, k % 8); end
      if (out_valid !== exp_ov) begin failures++; $display("FAIL stream_ov k=%0d got=%h exp=%h", k, out_valid, exp_ov); end
      if (out_data !== 8'(k)) begin failures++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, out_data, k); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 8'h00) begin failures++; $display("FAIL stream_drain got=%h exp=00", out_valid); end
  endtask

  task automatic test_sparse_mask();
    logic [2:0] exp_sel [5];
    exp_sel = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5};
    apply_reset();
    ch_en      = 8'b1010_0100;
    sink_ready = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(8'h50 + k);
      @(posedge clk);
      #1;
      checks += 2;
      if (sel !== exp_sel[k]) begin failures++; $display("FAIL sparse_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel[k]); end
      if ((out_valid & ~ch_en) !== 8'h00) begin failures++; $display("FAIL sparse_disabled k=%0d got=%h exp=00", k, out_valid & ~ch_en); end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    ch_en      = 8'h08;
    sink_ready = 8'hF7;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(negedge clk);
    in_data = 8'h44;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks += 3;
      if (in_ready !== 1'b0)   begin failures++; $display("FAIL bp_ready k=%0d got=%b exp=0", k, in_ready); end
      if (out_valid !== 8'h08) begin failures++; $display("FAIL bp_ov k=%0d got=%h exp=08", k, out_valid); end
      if (out_data !== 8'h33)  begin failures++; $display("FAIL bp_data k=%0d got=%h exp=33", k, out_data); end
      @(negedge clk);
    end
    sink_ready = 8'hFF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    checks += 3;
    if (out_data !== 8'h44)  begin failures++; $display("FAIL bp_next_data got=%h exp=44", out_data); end
    if (out_valid !== 8'h08) begin failures++; $display("FAIL bp_next_ov got=%h exp=08", out_valid); end
    if (sel !== 3'd3)        begin failures++; $display("FAIL bp_next_sel got=%0d exp=3", sel); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_grant_fixed();
    apply_reset();
    ch_en      = 8'hC0;
    sink_ready = 8'h00;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h66;
    @(negedge clk);
    in_valid = 1'b0;
    ch_en    = 8'h80;
    @(posedge clk);
    #1;
    checks += 2;
    if (out_valid !== 8'h40) begin failures++; $display("FAIL fixed_ov got=%h exp=40", out_valid); end
    if (out_data !== 8'h66)  begin failures++; $display("FAIL fixed_data got=%h exp=66", out_data); end
    @(negedge clk);
    ch_en      = 8'hC0;
    sink_ready = 8'hFF;
    in_valid   = 1'b1;
    in_data    = 8'h77;
    @(posedge clk);
    #1;
    checks += 2;
    if (sel !== 3'd7)        begin failures++; $display("FAIL fixed_next_sel got=%0d exp=7", sel); end
    if (out_valid !== 8'h80) begin failures++; $display("FAIL fixed_next_ov got=%h exp=80", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    ch_en      = 8'h80;
    sink_ready = 8'hFF;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(negedge clk);
    ch_en   = 8'h01;
    in_data = 8'h02;
    @(posedge clk);
    #1;
    checks += 2;
    if (sel !== 3'd0)        begin failures++; $display("FAIL wrap_sel got=%0d exp=0", sel); end
    if (out_valid !== 8'h01) begin failures++; $display("FAIL wrap_ov got=%h exp=01", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    apply_reset();
    sink_ready = 8'hFF;
    ch_en      = 8'h00;
    in_valid   = 1'b1;
    in_data    = 8'h99;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks += 2;
      if (stall !== 1'b1)    begin failures++; $display("FAIL stall_flag k=%0d got=%b exp=1", k, stall); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready k=%0d got=%b exp=0", k, in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 8'h00) begin failures++; $display("FAIL stall_ov k=%0d got=%h exp=00", k, out_valid); end
      @(negedge clk);
    end
    ch_en = 8'h10;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL stall_clear got=%b exp=0", stall); end
    @(posedge clk);
    #1;
    checks += 3;
    if (sel !== 3'd4)        begin failures++; $display("FAIL stall_sel got=%0d exp=4", sel); end
    if (out_valid !== 8'h10) begin failures++; $display("FAIL stall_out_ov got=%h exp=10", out_valid); end
    if (out_data !== 8'h99)  begin failures++; $display("FAIL stall_data got=%h exp=99", out_data); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    ch_en      = 8'h20;
    sink_ready = 8'h00;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h20) begin failures++; $display("FAIL mid_hold_ov got=%h exp=20", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 8'h00) begin failures++; $display("FAIL mid_reset_ov got=%h exp=00", out_valid); end
    @(negedge clk);
    rst_n      = 1'b1;
    ch_en      = 8'hFF;
    sink_ready = 8'hFF;
    in_valid   = 1'b1;
    in_data    = 8'hBB;
    @(posedge clk);
    #1;
    checks += 2;
    if (sel !== 3'd0)        begin failures++; $display("FAIL post_reset_sel got=%0d exp=0", sel); end
    if (out_valid !== 8'h01) begin failures++; $display("FAIL post_reset_ov got=%h exp=01", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    ch_en      = 8'h00;
    sink_ready = 8'h00;
    test_reset();
    test_stream_all();
    test_sparse_mask();
    test_backpressure();
    test_grant_fixed();
    test_wrap();
    test_stall();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
